fp_norm_round: RTL

- Back end of the FPU add/sub datapath.
- Consumes the 28-bit raw mantissa sum, carry-out, sign and pre-alignment exponent produced by the 28-bit add/sub stage.
- Normalizes iteratively, one left shift per cycle, then rounds to nearest-even and packs an IEEE-754 single result.
- valid/ready handshake on both sides; one operation in flight.

---
 rtl/fp_norm_round.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fp_norm_round.sv
// fp_norm_round: add/sub back end.
// Normalizes one shift per cycle, rounds to nearest-even, packs IEEE single.
module fp_norm_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int MANT_W = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign_in,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic [MANT_W-1:0]       mant_in,
    input  logic                    co_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CARRY,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic                   r_sign;
    logic                   r_co;
    logic [EXP_W:0]         r_exp;
    logic [MANT_W-1:0]      r_mant;
    logic [EXP_W+FRAC_W:0]  r_result;
    logic                   r_ovf;
    logic                   r_unf;
    logic                   r_inx;

    logic                   w_stop;
    logic                   w_up;
    logic [FRAC_W+1:0]      w_m;
    logic                   w_int;
    logic [EXP_W:0]         w_rexp;
    logic [FRAC_W-1:0]      w_rfrac;
    logic                   w_ovf;
    logic                   w_inx;
    logic [EXP_W-1:0]       w_efield;
    logic [EXP_W+FRAC_W:0]  w_res;
    logic                   w_unf;

    // normalization ends on zero, a set integer bit, or the denormal floor
    assign w_stop = ~|r_mant | r_mant[MANT_W-1] | (r_exp == (EXP_W+1)'(1));

    // round-to-nearest-even and packing of the normalized mantissa
    always_comb begin
        w_up     = r_mant[3] & ((|r_mant[2:0]) | r_mant[4]);
        w_m      = {1'b0, r_mant[MANT_W-1:4]} + {{(FRAC_W+1){1'b0}}, w_up};
        w_int    = w_m[FRAC_W+1] | w_m[FRAC_W];
        w_rexp   = r_exp;
        w_rfrac  = w_m[FRAC_W-1:0];
        if (w_m[FRAC_W+1]) begin
            w_rexp  = r_exp + (EXP_W+1)'(1);
            w_rfrac = '0;
        end
        w_inx    = |r_mant[3:0];
        w_ovf    = (w_rexp >= {1'b0, {EXP_W{1'b1}}});
        w_efield = w_int ? w_rexp[EXP_W-1:0] : '0;
        w_res    = {r_sign, w_efield, w_rfrac};
        if (w_ovf) begin
            w_res    = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            w_inx    = 1'b1;
            w_efield = {EXP_W{1'b1}};
        end
        w_unf    = (w_efield == '0) & w_inx;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid) w_next = S_CARRY;
            S_CARRY: w_next = S_NORM;
            S_NORM:  if (w_stop) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // datapath: capture, carry fold, shift, and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_co     <= 1'b0;
            r_exp    <= '0;
            r_mant   <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inx    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_sign <= sign_in;
                    r_co   <= co_in;
                    r_exp  <= {1'b0, exp_in};
                    r_mant <= mant_in;
                end
                S_CARRY: if (r_co) begin
                    r_mant <= {1'b1, r_mant[MANT_W-1:2], |r_mant[1:0]};
                    r_exp  <= r_exp + (EXP_W+1)'(1);
                end
                S_NORM: if (!w_stop) begin
                    r_mant <= r_mant << 1;
                    r_exp  <= r_exp - (EXP_W+1)'(1);
                end
                S_ROUND: begin
                    r_result <= w_res;
                    r_ovf    <= w_ovf;
                    r_unf    <= w_unf;
                    r_inx    <= w_inx;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign inexact   = r_inx;

endmodule
